prefetch_bus_fetcher: RTL and testbench

Bus-side fill engine for the CPU prefetch queue. It issues 16-bit word reads on the memory bus at the current fetch address and pushes the returned bytes into the queue: two bytes for an even address, one byte for an odd address. It defers to CPU data accesses and stops when the queue reports full. A flush with a new address redirects fetching after a jump; any in-flight word is discarded.

---
 rtl/prefetch_bus_fetcher.sv | 119 +++++++++++
 tb/tb_prefetch_bus_fetcher.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_bus_fetcher.sv
// Bus-side fill engine for the CPU prefetch queue: fetches 16-bit words at the
// current fetch address and pushes one or two bytes per word into the queue.
module prefetch_bus_fetcher #(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        cpu_mem_req,
  input  logic        queue_full,
  input  logic        flush,
  input  logic [15:0] flush_addr,
  output logic        bus_req,
  output logic [15:0] bus_addr,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        push,
  output logic [15:0] push_data,
  output logic        push_odd,
  output logic [15:0] fetch_addr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PUSH,
    DISCARD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        push_r;
  logic        start_fetch;
  logic [15:0] addr_advanced;

  // queue_full and cpu_mem_req only matter here, while deciding to start
  assign start_fetch   = fetch_en & ~cpu_mem_req & ~queue_full & ~flush;
  assign addr_advanced = fetch_addr + (push_odd ? 16'd1 : 16'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_fetch) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          state_next = bus_ack ? IDLE : DISCARD;
        end else if (bus_ack) begin
          state_next = PUSH;
        end
      end
      PUSH: begin
        state_next = IDLE;
      end
      DISCARD: begin
        if (bus_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The bus cannot abort, so a flushed request keeps bus_req up in DISCARD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_req  <= 1'b0;
      bus_addr <= 16'h0000;
    end else begin
      bus_req <= (state_next == REQ) || (state_next == DISCARD);
      if ((state == IDLE) && (state_next == REQ)) begin
        bus_addr <= {fetch_addr[15:1], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_r    <= 1'b0;
      push_data <= 16'h0000;
      push_odd  <= 1'b0;
    end else begin
      push_r <= (state_next == PUSH);
      if (state_next == PUSH) begin
        push_data <= fetch_addr[0] ? {8'h00, bus_rdata[15:8]} : bus_rdata;
        push_odd  <= fetch_addr[0];
      end
    end
  end

  // A flush overrides the post-push advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr <= RESET_ADDR;
    end else if (flush) begin
      fetch_addr <= flush_addr;
    end else if (state == PUSH) begin
      fetch_addr <= addr_advanced;
    end
  end

  assign push = push_r & ~flush;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_prefetch_bus_fetcher.sv
// Directed self-checking bench for prefetch_bus_fetcher with a wait-state
// programmable memory responder and a push/request logging monitor.
module tb_prefetch_bus_fetcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        cpu_mem_req;
  logic        queue_full;
  logic        flush;
  logic [15:0] flush_addr;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = 16'h0000;
  logic        push;
  logic [15:0] push_data;
  logic        push_odd;
  logic [15:0] fetch_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wait_states = 0;
  int wait_cnt = 0;
  int cycle = 0;
  int push_cnt = 0;
  int req_cnt = 0;
  int overlap_cnt = 0;
  logic        req_prev = 1'b0;
  logic [15:0] push_data_log[$];
  logic        push_odd_log[$];
  int          push_cycle_log[$];
  logic [15:0] req_addr_log[$];

  always #5 clk = ~clk;

  prefetch_bus_fetcher #(.RESET_ADDR(16'h0100)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fetch_en(fetch_en),
    .cpu_mem_req(cpu_mem_req),
    .queue_full(queue_full),
    .flush(flush),
    .flush_addr(flush_addr),
    .bus_req(bus_req),
    .bus_addr(bus_addr),
    .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
    .push(push),
    .push_data(push_data),
    .push_odd(push_odd),
    .fetch_addr(fetch_addr),
    .busy(busy)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0100) return 16'h1234;
    if (a == 16'h0202) return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  // Memory responder: acks after wait_states cycles of a held request
  always @(posedge clk) begin
    cycle++;
    #2;
    bus_ack = 1'b0;
    if (reset_n && bus_req) begin
      if (wait_cnt >= wait_states) begin
        bus_ack   = 1'b1;
        bus_rdata = mem_word(bus_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (push) begin
        push_data_log.push_back(push_data);
        push_odd_log.push_back(push_odd);
        push_cycle_log.push_back(cycle);
        push_cnt++;
        if (bus_req) overlap_cnt++;
      end
      if (bus_req && !req_prev) begin
        req_addr_log.push_back(bus_addr);
        req_cnt++;
      end
    end
    req_prev = bus_req;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pushes(input int target, input int budget, input string name);
    int n = 0;
    while (push_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (push_cnt < target) begin
      errors++;
      $display("[TB] FAIL %s: push count %0d, expected %0d within %0d cycles", name, push_cnt, target, budget);
    end
  endtask

  task automatic wait_req(input int budget, input string name);
    int n = 0;
    while (bus_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: bus_req never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic flush_to(input logic [15:0] addr);
    flush_addr = addr;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fetch_en = 1'b0;
    cpu_mem_req = 1'b0;
    queue_full = 1'b0;
    flush = 1'b0;
    flush_addr = 16'h0000;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req: got %b, expected 0", bus_req); end
    checks++; if (bus_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bus_addr: got %h, expected 0000", bus_addr); end
    checks++; if (push !== 1'b0) begin errors++; $display("[TB] FAIL reset_push: got %b, expected 0", push); end
    checks++; if (push_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_push_data: got %h, expected 0000", push_data); end
    checks++; if (push_odd !== 1'b0) begin errors++; $display("[TB] FAIL reset_push_odd: got %b, expected 0", push_odd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (fetch_addr !== 16'h0100) begin errors++; $display("[TB] FAIL reset_fetch_addr: got %h, expected 0100", fetch_addr); end
  endtask

  task automatic test_basic_fetch();
    fetch_en = 1'b1;
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_req_n1: got %b, expected 1", bus_req); end
    checks++; if (bus_addr !== 16'h0100) begin errors++; $display("[TB] FAIL basic_bus_addr: got %h, expected 0100", bus_addr); end
    checks++; if (push !== 1'b0) begin errors++; $display("[TB] FAIL basic_push_n1: got %b, expected 0", push); end
    tick();
    checks++; if (push !== 1'b1) begin errors++; $display("[TB] FAIL basic_push_n2: got %b, expected 1", push); end
    checks++; if (push_data !== 16'h1234) begin errors++; $display("[TB] FAIL basic_push_data: got %h, expected 1234", push_data); end
    checks++; if (push_odd !== 1'b0) begin errors++; $display("[TB] FAIL basic_push_odd: got %b, expected 0", push_odd); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_req_n2: got %b, expected 0", bus_req); end
    fetch_en = 1'b0;
    tick();
    checks++; if (fetch_addr !== 16'h0102) begin errors++; $display("[TB] FAIL basic_fetch_addr: got %h, expected 0102", fetch_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_n3: got %b, expected 0", busy); end
    tick();
  endtask

  task automatic test_flush_odd();
    int base;
    int rbase;
    flush_to(16'h0203);
    checks++; if (fetch_addr !== 16'h0203) begin errors++; $display("[TB] FAIL odd_flush_addr: got %h, expected 0203", fetch_addr); end
    base = push_cnt;
    rbase = req_cnt;
    fetch_en = 1'b1;
    wait_pushes(base + 1, 10, "odd_first_push");
    checks++; if (req_addr_log[rbase] !== 16'h0202) begin errors++; $display("[TB] FAIL odd_bus_addr: got %h, expected 0202", req_addr_log[rbase]); end
    checks++; if (push_data_log[base] !== 16'h00BE) begin errors++; $display("[TB] FAIL odd_push_data: got %h, expected 00be", push_data_log[base]); end
    checks++; if (push_odd_log[base] !== 1'b1) begin errors++; $display("[TB] FAIL odd_push_odd: got %b, expected 1", push_odd_log[base]); end
    tick();
    checks++; if (fetch_addr !== 16'h0204) begin errors++; $display("[TB] FAIL odd_fetch_addr: got %h, expected 0204", fetch_addr); end
    wait_pushes(base + 2, 10, "odd_second_push");
    fetch_en = 1'b0;
    checks++; if (req_addr_log[rbase + 1] !== 16'h0204) begin errors++; $display("[TB] FAIL odd_next_addr: got %h, expected 0204", req_addr_log[rbase + 1]); end
    checks++; if (push_odd_log[base + 1] !== 1'b0) begin errors++; $display("[TB] FAIL odd_next_push_odd: got %b, expected 0", push_odd_log[base + 1]); end
    checks++; if (push_data_log[base + 1] !== 16'h585E) begin errors++; $display("[TB] FAIL odd_next_data: got %h, expected 585e", push_data_log[base + 1]); end
    tick();
    tick();
    checks++; if (fetch_addr !== 16'h0206) begin errors++; $display("[TB] FAIL odd_final_addr: got %h, expected 0206", fetch_addr); end
  endtask

  task automatic test_flush_wait();
    int base;
    int rbase;
    wait_states = 3;
    base = push_cnt;
    rbase = req_cnt;
    fetch_en = 1'b1;
    wait_req(5, "discard_req_start");
    flush_to(16'h0300);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL discard_req_held1: got %b, expected 1", bus_req); end
    checks++; if (fetch_addr !== 16'h0300) begin errors++; $display("[TB] FAIL discard_fetch_addr: got %h, expected 0300", fetch_addr); end
    tick();
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL discard_req_held3: got %b, expected 1", bus_req); end
    tick();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL discard_req_drop: got %b, expected 0", bus_req); end
    checks++; if (push_cnt !== base) begin errors++; $display("[TB] FAIL discard_no_push: got %0d pushes, expected %0d", push_cnt, base); end
    wait_pushes(base + 1, 20, "discard_refetch");
    fetch_en = 1'b0;
    checks++; if (req_addr_log[rbase + 1] !== 16'h0300) begin errors++; $display("[TB] FAIL discard_new_addr: got %h, expected 0300", req_addr_log[rbase + 1]); end
    checks++; if (push_data_log[base] !== 16'h595A) begin errors++; $display("[TB] FAIL discard_new_data: got %h, expected 595a", push_data_log[base]); end
    checks++; if (req_cnt !== rbase + 2) begin errors++; $display("[TB] FAIL discard_req_count: got %0d, expected %0d", req_cnt, rbase + 2); end
    wait_states = 0;
    tick();
    tick();
  endtask

  task automatic test_hold();
    int base;
    int rbase;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) queue_full = 1'b1;
      else cpu_mem_req = 1'b1;
      base = push_cnt;
      rbase = req_cnt;
      fetch_en = 1'b1;
      repeat (4) tick();
      checks++; if (bus_req !== 1'b0 || req_cnt !== rbase) begin errors++; $display("[TB] FAIL hold_%0d_no_req: got bus_req %b reqs %0d, expected 0 reqs %0d", k, bus_req, req_cnt, rbase); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_%0d_busy: got %b, expected 0", k, busy); end
      queue_full = 1'b0;
      cpu_mem_req = 1'b0;
      tick();
      checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_%0d_restart: got %b, expected 1", k, bus_req); end
      wait_pushes(base + 1, 10, "hold_push");
      fetch_en = 1'b0;
      checks++; if (push_data_log[base] !== ((k == 0) ? 16'h5958 : 16'h595E)) begin errors++; $display("[TB] FAIL hold_%0d_data: got %h, expected %h", k, push_data_log[base], (k == 0) ? 16'h5958 : 16'h595E); end
      tick();
      tick();
    end
  endtask

  task automatic test_back_to_back_wrap();
    int base;
    int rbase;
    flush_to(16'hFFFF);
    base = push_cnt;
    rbase = req_cnt;
    fetch_en = 1'b1;
    wait_pushes(base + 2, 12, "wrap_odd_pushes");
    fetch_en = 1'b0;
    checks++; if (req_addr_log[rbase] !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_addr_fffe: got %h, expected fffe", req_addr_log[rbase]); end
    checks++; if (push_odd_log[base] !== 1'b1) begin errors++; $display("[TB] FAIL wrap_odd_flag: got %b, expected 1", push_odd_log[base]); end
    checks++; if (push_data_log[base] !== 16'h00A5) begin errors++; $display("[TB] FAIL wrap_odd_data: got %h, expected 00a5", push_data_log[base]); end
    checks++; if (req_addr_log[rbase + 1] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_next_addr: got %h, expected 0000", req_addr_log[rbase + 1]); end
    checks++; if (push_data_log[base + 1] !== 16'h5A5A) begin errors++; $display("[TB] FAIL wrap_next_data: got %h, expected 5a5a", push_data_log[base + 1]); end
    checks++; if (push_cycle_log[base + 1] - push_cycle_log[base] !== 3) begin errors++; $display("[TB] FAIL back_to_back_spacing: got %0d cycles, expected 3", push_cycle_log[base + 1] - push_cycle_log[base]); end
    tick();
    checks++; if (fetch_addr !== 16'h0002) begin errors++; $display("[TB] FAIL wrap_after_addr: got %h, expected 0002", fetch_addr); end
    tick();
    flush_to(16'hFFFE);
    base = push_cnt;
    fetch_en = 1'b1;
    wait_pushes(base + 1, 10, "wrap_even_push");
    fetch_en = 1'b0;
    checks++; if (push_data_log[base] !== 16'hA5A4 || push_odd_log[base] !== 1'b0) begin errors++; $display("[TB] FAIL wrap_even_data: got %h odd %b, expected a5a4 odd 0", push_data_log[base], push_odd_log[base]); end
    tick();
    checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_even_addr: got %h, expected 0000", fetch_addr); end
    tick();
  endtask

  task automatic test_async_reset();
    int base;
    int rbase;
    wait_states = 3;
    fetch_en = 1'b1;
    wait_req(5, "areset_req_start");
    reset_n = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL areset_bus_req: got %b, expected 0", bus_req); end
    checks++; if (bus_addr !== 16'h0000) begin errors++; $display("[TB] FAIL areset_bus_addr: got %h, expected 0000", bus_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy: got %b, expected 0", busy); end
    checks++; if (push !== 1'b0 || push_data !== 16'h0000 || push_odd !== 1'b0) begin errors++; $display("[TB] FAIL areset_push: got %b %h %b, expected 0 0000 0", push, push_data, push_odd); end
    checks++; if (fetch_addr !== 16'h0100) begin errors++; $display("[TB] FAIL areset_fetch_addr: got %h, expected 0100", fetch_addr); end
    fetch_en = 1'b0;
    wait_states = 0;
    tick();
    tick();
    reset_n = 1'b1;
    base = push_cnt;
    rbase = req_cnt;
    fetch_en = 1'b1;
    wait_pushes(base + 1, 10, "areset_restart");
    fetch_en = 1'b0;
    checks++; if (req_addr_log[rbase] !== 16'h0100) begin errors++; $display("[TB] FAIL areset_restart_addr: got %h, expected 0100", req_addr_log[rbase]); end
    checks++; if (push_data_log[base] !== 16'h1234) begin errors++; $display("[TB] FAIL areset_restart_data: got %h, expected 1234", push_data_log[base]); end
    tick();
    tick();
  endtask

  initial begin
    $display("[TB] starting prefetch_bus_fetcher bench");
    test_reset();
    test_basic_fetch();
    test_flush_odd();
    test_flush_wait();
    test_hold();
    test_back_to_back_wrap();
    test_async_reset();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL push_bus_req_overlap: got %0d overlaps, expected 0", overlap_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
